// File: rtl/insn_cache_nway_pkg.sv
// Shared types and address-field helpers for the N-way instruction cache.
// Field widths derive from SETS and LINE_WORDS so every file splits the address identically.
package insn_cache_nway_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS_REQ,
        ST_REFILL,
        ST_RESPOND
    } state_t;

    localparam int DEF_WAYS       = 4;
    localparam int DEF_SETS       = 256;
    localparam int DEF_LINE_WORDS = 4;

    function automatic int word_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int sets, input int line_words);
        return 32 - index_bits(sets) - word_bits(line_words) - 2;
    endfunction

endpackage

// File: rtl/insn_cache_nway_plru.sv
// PLRU-m next-state and victim selection; purely combinational, zero latency, no flow control.
// Victim is the lowest invalid way, else the lowest way whose MRU bit is clear.
module plru_m #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-1:0]         i_bits,
    input  logic [$clog2(WAYS)-1:0] i_way,
    input  logic [WAYS-1:0]         i_valid,
    output logic [WAYS-1:0]         o_bits,
    output logic [$clog2(WAYS)-1:0] o_victim
);
    localparam int WAYB = $clog2(WAYS);

    logic [WAYS-1:0] w_set;
    logic            w_found;

    always_comb begin
        w_set  = i_bits | (WAYS'(1) << i_way);
        // Saturation restarts the history with only the just-accessed way marked.
        o_bits = (&w_set) ? (WAYS'(1) << i_way) : w_set;
    end

    always_comb begin
        o_victim = '0;
        w_found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found && !i_valid[w]) begin
                o_victim = WAYB'(w);
                w_found  = 1'b1;
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found && !i_bits[w]) begin
                o_victim = WAYB'(w);
                w_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/insn_cache_nway.sv
// Blocking N-way set-associative instruction cache with PLRU-m replacement and line refill.
// Hit latency 2 cycles, one request per 2 cycles; REQ_READY only in IDLE, MEM_REQ held until MEM_ACK.
module insn_cache_nway
    import insn_cache_nway_pkg::*;
#(
    parameter int WAYS       = DEF_WAYS,
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        REQ_VALID,
    input  logic [31:0] REQ_ADDR,
    output logic        REQ_READY,
    output logic        RSP_VALID,
    output logic [31:0] RSP_DATA,
    output logic        MEM_REQ,
    output logic [31:0] MEM_ADDR,
    input  logic        MEM_ACK,
    input  logic        MEM_RVALID,
    input  logic [31:0] MEM_RDATA,
    input  logic        INV_ALL
);
    localparam int WB   = word_bits(LINE_WORDS);
    localparam int IB   = index_bits(SETS);
    localparam int TB   = tag_bits(SETS, LINE_WORDS);
    localparam int WAYB = $clog2(WAYS);

    state_t            r_state;
    logic [29:0]       r_waddr;
    logic              r_valid [WAYS][SETS];
    logic [WAYS-1:0]   r_mru   [SETS];
    logic [TB-1:0]     r_tag   [WAYS][SETS];
    logic [31:0]       r_data  [WAYS][SETS][LINE_WORDS];
    logic [WAYB-1:0]   r_victim;
    logic [WB-1:0]     r_cnt;
    logic              r_inv_pend;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_data;
    logic              r_mem_req;
    logic [31:0]       r_mem_addr;

    logic [TB-1:0]     w_tag;
    logic [IB-1:0]     w_idx;
    logic [WB-1:0]     w_word;
    logic [WAYS-1:0]   w_valid_vec;
    logic [WAYS-1:0]   w_hit_vec;
    logic              w_hit;
    logic [WAYB-1:0]   w_hit_way;
    logic [WAYB-1:0]   w_plru_way;
    logic [WAYS-1:0]   w_plru_bits;
    logic [WAYB-1:0]   w_plru_victim;
    logic              w_last_beat;
    logic              w_clr;
    logic              w_unused;

    assign w_unused = &{1'b0, REQ_ADDR[1:0]};

    assign w_tag  = r_waddr[29 -: TB];
    assign w_idx  = r_waddr[WB +: IB];
    assign w_word = r_waddr[WB-1:0];

    always_comb begin
        w_valid_vec = '0;
        w_hit_vec   = '0;
        w_hit_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_valid_vec[w] = r_valid[w][w_idx];
            w_hit_vec[w]   = r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag);
            if (w_hit_vec[w]) w_hit_way = WAYB'(w);
        end
    end

    assign w_hit       = $onehot(w_hit_vec);
    assign w_plru_way  = (r_state == ST_LOOKUP) ? w_hit_way : r_victim;
    assign w_last_beat = MEM_RVALID && (r_cnt == WB'(LINE_WORDS - 1));

    // A deferred invalidate lands on the RESPOND->IDLE transition, after the refilled line was used.
    assign w_clr = ((r_state == ST_IDLE || r_state == ST_LOOKUP) && INV_ALL) ||
                   ((r_state == ST_RESPOND) && (INV_ALL || r_inv_pend));

    plru_m #(.WAYS(WAYS)) u_plru (
        .i_bits   (r_mru[w_idx]),
        .i_way    (w_plru_way),
        .i_valid  (w_valid_vec),
        .o_bits   (w_plru_bits),
        .o_victim (w_plru_victim)
    );

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state     <= ST_IDLE;
            r_waddr     <= '0;
            r_victim    <= '0;
            r_cnt       <= '0;
            r_inv_pend  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_mru[s] <= '0;
                for (int w = 0; w < WAYS; w++) r_valid[w][s] <= 1'b0;
            end
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        r_waddr <= REQ_ADDR[31:2];
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (INV_ALL) begin
                        r_state <= ST_IDLE;
                    end else if (w_hit) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_data   <= r_data[w_hit_way][w_idx][w_word];
                        r_mru[w_idx] <= w_plru_bits;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_victim   <= w_plru_victim;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {w_tag, w_idx, {(WB + 2){1'b0}}};
                        r_state    <= ST_MISS_REQ;
                    end
                end
                ST_MISS_REQ: begin
                    if (INV_ALL) r_inv_pend <= 1'b1;
                    if (MEM_ACK) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (INV_ALL) r_inv_pend <= 1'b1;
                    if (w_last_beat) begin
                        r_cnt                    <= '0;
                        r_valid[r_victim][w_idx] <= 1'b1;
                        r_mru[w_idx]             <= w_plru_bits;
                        r_state                  <= ST_RESPOND;
                    end else if (MEM_RVALID) begin
                        r_cnt <= r_cnt + WB'(1);
                    end
                end
                ST_RESPOND: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= r_data[r_victim][w_idx][w_word];
                    r_inv_pend  <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_clr) begin
                for (int s = 0; s < SETS; s++) begin
                    r_mru[s] <= '0;
                    for (int w = 0; w < WAYS; w++) r_valid[w][s] <= 1'b0;
                end
            end
        end
    end

    // Tag and data storage carry no reset; validity alone says whether contents mean anything.
    always_ff @(posedge CLK) begin
        if (r_state == ST_REFILL && MEM_RVALID) begin
            r_data[r_victim][w_idx][r_cnt] <= MEM_RDATA;
            if (w_last_beat) r_tag[r_victim][w_idx] <= w_tag;
        end
    end

    assign REQ_READY = (r_state == ST_IDLE);
    assign RSP_VALID = r_rsp_valid;
    assign RSP_DATA  = r_rsp_data;
    assign MEM_REQ   = r_mem_req;
    assign MEM_ADDR  = r_mem_addr;

endmodule

// File: tb/tb_insn_cache_nway.sv
// Directed bench: default-parameter cache for hit/miss/replacement/invalidate/reset,
// plus WAYS=2 and WAYS=8 instances with 8-word lines driven in lockstep for a sequential sweep.
module tb_insn_cache_nway;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic        REQ_VALID, REQ_READY, RSP_VALID, MEM_REQ, MEM_ACK, MEM_RVALID, INV_ALL;
    logic [31:0] REQ_ADDR, RSP_DATA, MEM_ADDR, MEM_RDATA;

    logic        s_req_valid, s_mem_ack, s_rvalid;
    logic [31:0] s_req_addr, s_rdata;
    logic        s2_ready, s2_rsp_valid, s2_mem_req, s8_ready, s8_rsp_valid, s8_mem_req;
    logic [31:0] s2_rsp_data, s2_mem_addr, s8_rsp_data, s8_mem_addr;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    insn_cache_nway dut (
        .CLK(CLK), .nRESET(nRESET),
        .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR), .REQ_READY(REQ_READY),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK),
        .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA), .INV_ALL(INV_ALL)
    );

    insn_cache_nway #(.WAYS(2), .SETS(16), .LINE_WORDS(8)) dut_w2 (
        .CLK(CLK), .nRESET(nRESET),
        .REQ_VALID(s_req_valid), .REQ_ADDR(s_req_addr), .REQ_READY(s2_ready),
        .RSP_VALID(s2_rsp_valid), .RSP_DATA(s2_rsp_data),
        .MEM_REQ(s2_mem_req), .MEM_ADDR(s2_mem_addr), .MEM_ACK(s_mem_ack),
        .MEM_RVALID(s_rvalid), .MEM_RDATA(s_rdata), .INV_ALL(1'b0)
    );

    insn_cache_nway #(.WAYS(8), .SETS(16), .LINE_WORDS(8)) dut_w8 (
        .CLK(CLK), .nRESET(nRESET),
        .REQ_VALID(s_req_valid), .REQ_ADDR(s_req_addr), .REQ_READY(s8_ready),
        .RSP_VALID(s8_rsp_valid), .RSP_DATA(s8_rsp_data),
        .MEM_REQ(s8_mem_req), .MEM_ADDR(s8_mem_addr), .MEM_ACK(s_mem_ack),
        .MEM_RVALID(s_rvalid), .MEM_RDATA(s_rdata), .INV_ALL(1'b0)
    );

    // Backing memory contents: each word is its own address with a fixed pattern mixed in.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One fetch on the default DUT with exact cycle expectations; 16-byte lines, gap after beat 1.
    task automatic fetch(input logic [31:0] a, input bit exp_hit, input bit inv_acc,
                         input int inv_beat, input int rst_beat);
        logic [31:0] line;
        line = {a[31:4], 4'h0};
        @(negedge CLK);
        chk($sformatf("ready@%h", a), {31'b0, REQ_READY}, 32'd1);
        REQ_VALID = 1'b1; REQ_ADDR = a; INV_ALL = inv_acc;
        @(negedge CLK);
        REQ_VALID = 1'b0; INV_ALL = 1'b0;
        chk($sformatf("busy@%h", a), {31'b0, REQ_READY}, 32'd0);
        @(negedge CLK);
        if (exp_hit) begin
            chk($sformatf("hit_valid@%h", a), {31'b0, RSP_VALID}, 32'd1);
            chk($sformatf("hit_data@%h", a), RSP_DATA, mem_word(a));
            chk($sformatf("hit_no_memreq@%h", a), {31'b0, MEM_REQ}, 32'd0);
            @(negedge CLK);
            chk($sformatf("hit_once@%h", a), {31'b0, RSP_VALID}, 32'd0);
        end else begin
            chk($sformatf("miss_memreq@%h", a), {31'b0, MEM_REQ}, 32'd1);
            chk($sformatf("miss_memaddr@%h", a), MEM_ADDR, line);
            @(negedge CLK);
            chk($sformatf("memreq_held@%h", a), {31'b0, MEM_REQ}, 32'd1);
            chk($sformatf("memaddr_held@%h", a), MEM_ADDR, line);
            MEM_ACK = 1'b1;
            @(negedge CLK);
            MEM_ACK = 1'b0;
            for (int k = 0; k < 4; k++) begin
                MEM_RVALID = 1'b1;
                MEM_RDATA  = mem_word(line + 32'(k * 4));
                INV_ALL    = (k == inv_beat);
                if (k == rst_beat) begin
                    nRESET = 1'b0;
                    #1;
                    chk("rst_memreq", {31'b0, MEM_REQ}, 32'd0);
                    chk("rst_rspvalid", {31'b0, RSP_VALID}, 32'd0);
                    chk("rst_memaddr", MEM_ADDR, 32'd0);
                    @(negedge CLK);
                    nRESET = 1'b1; MEM_RVALID = 1'b0; INV_ALL = 1'b0;
                    return;
                end
                @(negedge CLK);
                MEM_RVALID = 1'b0; INV_ALL = 1'b0;
                if (k == 1) @(negedge CLK);
            end
            chk($sformatf("respond_quiet@%h", a), {31'b0, RSP_VALID}, 32'd0);
            @(negedge CLK);
            chk($sformatf("miss_valid@%h", a), {31'b0, RSP_VALID}, 32'd1);
            chk($sformatf("miss_data@%h", a), RSP_DATA, mem_word(a));
            @(negedge CLK);
            chk($sformatf("miss_once@%h", a), {31'b0, RSP_VALID}, 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  refills2, refills8;
        logic got;
        logic [31:0] sline;
        nRESET = 1'b0; REQ_VALID = 1'b0; REQ_ADDR = '0; MEM_ACK = 1'b0;
        MEM_RVALID = 1'b0; MEM_RDATA = '0; INV_ALL = 1'b0;
        s_req_valid = 1'b0; s_req_addr = '0; s_mem_ack = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        repeat (3) @(negedge CLK);
        chk("reset_rspvalid", {31'b0, RSP_VALID}, 32'd0);
        chk("reset_rspdata", RSP_DATA, 32'd0);
        chk("reset_memreq", {31'b0, MEM_REQ}, 32'd0);
        chk("reset_memaddr", MEM_ADDR, 32'd0);
        nRESET = 1'b1;

        // Cold miss then hit on the same line; 0x1004 must return beat 1.
        fetch(32'h0000_1004, 1'b0, 1'b0, -1, -1);
        chk("cold_word_a1", RSP_DATA, 32'h5A5A_1004);
        fetch(32'h0000_1008, 1'b1, 1'b0, -1, -1);
        chk("hit_word_a2", RSP_DATA, 32'h5A5A_1008);

        // Fill set 0 with tags 1..4, touch tag 1, then tag 5 must evict way 1 (tag 2).
        fetch(32'h0000_2000, 1'b0, 1'b0, -1, -1);
        fetch(32'h0000_3000, 1'b0, 1'b0, -1, -1);
        fetch(32'h0000_4000, 1'b0, 1'b0, -1, -1);
        fetch(32'h0000_1000, 1'b1, 1'b0, -1, -1);
        fetch(32'h0000_5000, 1'b0, 1'b0, -1, -1);
        fetch(32'h0000_1000, 1'b1, 1'b0, -1, -1);
        fetch(32'h0000_300C, 1'b1, 1'b0, -1, -1);
        fetch(32'h0000_4004, 1'b1, 1'b0, -1, -1);
        fetch(32'h0000_5008, 1'b1, 1'b0, -1, -1);
        fetch(32'h0000_2000, 1'b0, 1'b0, -1, -1);

        // Invalidate during refill: response still arrives, the line is gone afterwards.
        fetch(32'h0000_6008, 1'b0, 1'b0, 2, -1);
        fetch(32'h0000_6008, 1'b0, 1'b0, -1, -1);
        fetch(32'h0000_600C, 1'b1, 1'b0, -1, -1);

        // Invalidate coincident with acceptance forces a miss on a resident line.
        fetch(32'h0000_6004, 1'b0, 1'b1, -1, -1);

        // Reset mid-refill, then the same fetch misses again.
        fetch(32'h0000_7004, 1'b0, 1'b0, -1, 1);
        fetch(32'h0000_7004, 1'b0, 1'b0, -1, -1);

        // Sequential sweep 0x00..0x7C on WAYS=2 and WAYS=8 with 8-word lines.
        refills2 = 0; refills8 = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            s_req_valid = 1'b1; s_req_addr = 32'(i * 4);
            @(negedge CLK);
            s_req_valid = 1'b0;
            sline = {s_req_addr[31:5], 5'h0};
            got = 1'b0;
            for (int c = 0; c < 30 && !got; c++) begin
                @(negedge CLK);
                if (s2_mem_req || s8_mem_req) begin
                    if (s2_mem_req) refills2++;
                    if (s8_mem_req) refills8++;
                    chk($sformatf("sweep_memaddr_w2@%h", s_req_addr), s2_mem_addr, sline);
                    chk($sformatf("sweep_memaddr_w8@%h", s_req_addr), s8_mem_addr, sline);
                    s_mem_ack = 1'b1;
                    @(negedge CLK);
                    s_mem_ack = 1'b0;
                    for (int k = 0; k < 8; k++) begin
                        s_rvalid = 1'b1;
                        s_rdata  = mem_word(sline + 32'(k * 4));
                        @(negedge CLK);
                    end
                    s_rvalid = 1'b0;
                end else if (s2_rsp_valid) begin
                    chk($sformatf("sweep_data_w2@%h", s_req_addr), s2_rsp_data, mem_word(s_req_addr));
                    chk($sformatf("sweep_valid_w8@%h", s_req_addr), {31'b0, s8_rsp_valid}, 32'd1);
                    chk($sformatf("sweep_data_w8@%h", s_req_addr), s8_rsp_data, mem_word(s_req_addr));
                    got = 1'b1;
                end
            end
            chk($sformatf("sweep_rsp_seen@%h", s_req_addr), {31'b0, got}, 32'd1);
        end
        chk("sweep_refills_w2", 32'(refills2), 32'd4);
        chk("sweep_refills_w8", 32'(refills8), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
